// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// UART receive controller in the RX oversampling clock domain. It
// synchronises rx_in, detects the start edge, oversamples each bit, shifts
// the payload in LSB first, checks parity and stop bits, and reports the
// result with one-cycle strobes.
//
// Build option: define UART_RX_MAJORITY_EN to resolve each bit by a 2-of-3
// majority of samples at edge_cnt P/2-1, P/2 and P/2+1 (decision point
// D = P/2+1). Without it, one sample is taken at P/2 (D = P/2).
//
// Handshake: there is no back-pressure. data_valid is a one-cycle strobe;
// p_data is valid in that cycle and holds until the next good frame. The
// consumer must take it in that cycle.
//
// Ports:
//   clk, rst_n  RX oversampling clock; asynchronous active-low reset
//   rx_in       serial line, idles high (asynchronous to clk)
//   par_en      frame carries a parity bit
//   par_typ     0 = even parity, 1 = odd parity
//   stop2       1 = two stop bits
//   prescale    clk cycles per bit (8, 16 or 32; anything else acts as 8)
//   p_data      received payload, LSB = first bit on the line
//   data_valid  strobe: good frame in p_data
//   par_err     strobe: parity mismatch
//   stp_err     strobe: a stop bit sampled low (once per failing bit)
//   busy        high whenever the FSM is not idle
//   state_dbg   FSM state (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP)
module uart_rx_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic               stop2,
    input  logic [PRESC_W-1:0] prescale,
    output logic [DATA_W-1:0]  p_data,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [PRESC_W-1:0] P8  = PRESC_W'(8);
    localparam logic [PRESC_W-1:0] P16 = PRESC_W'(16);
    localparam logic [PRESC_W-1:0] P32 = PRESC_W'(32);
    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic               sync1, rx_s;
    logic [2:0]         state;
    logic [PRESC_W-1:0] edge_cnt, p_lat, p_sel, half, d_pt;
    logic [3:0]         bit_cnt, last_k;
    logic               par_en_l, par_typ_l, stop2_l, frame_bad;
    logic [DATA_W-1:0]  shreg;
    logic               smp, at_d, at_wrap, exp_par;

    assign state_dbg = state;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // Unsupported prescale values fall back to 8.
    always_comb begin
        p_sel = P8;
        if (prescale == P16 || prescale == P32) p_sel = prescale;
    end

    assign half = p_lat >> 1;

`ifdef UART_RX_MAJORITY_EN
    logic maj0, maj1;

    // The first two votes are stored; the third is rx_s at the decision point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj0 <= 1'b1;
            maj1 <= 1'b1;
        end else begin
            if (edge_cnt == half - ONE) maj0 <= rx_s;
            if (edge_cnt == half)       maj1 <= rx_s;
        end
    end

    assign d_pt = half + ONE;
    assign smp  = (maj0 & maj1) | (maj0 & rx_s) | (maj1 & rx_s);
`else
    assign d_pt = half;
    assign smp  = rx_s;
`endif

    assign at_d    = (edge_cnt == d_pt);
    assign at_wrap = (edge_cnt == p_lat - ONE);
    // Index of the last stop bit, counting the start bit as 0.
    assign last_k  = 4'(DATA_W + 1) + {3'b000, par_en_l} + {3'b000, stop2_l};
    assign exp_par = (^shreg) ^ par_typ_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            p_lat      <= P8;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            stop2_l    <= 1'b0;
            frame_bad  <= 1'b0;
            shreg      <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != S_IDLE) begin
                if (at_wrap) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    edge_cnt <= edge_cnt + ONE;
                end
            end

            case (state)
                S_IDLE: begin
                    // This cycle is edge 0 of the start bit, so START begins at 1.
                    if (!rx_s) begin
                        state     <= S_START;
                        busy      <= 1'b1;
                        edge_cnt  <= ONE;
                        bit_cnt   <= '0;
                        p_lat     <= p_sel;
                        par_en_l  <= par_en;
                        par_typ_l <= par_typ;
                        stop2_l   <= stop2;
                        frame_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_d && smp) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (at_wrap) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_d) shreg <= {smp, shreg[DATA_W-1:1]};
                    if (at_wrap && bit_cnt == 4'(DATA_W))
                        state <= par_en_l ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (at_d && (smp != exp_par)) begin
                        par_err   <= 1'b1;
                        frame_bad <= 1'b1;
                    end
                    if (at_wrap) state <= S_STOP;
                end
                S_STOP: begin
                    if (at_d) begin
                        if (!smp) begin
                            stp_err   <= 1'b1;
                            frame_bad <= 1'b1;
                        end
                        // Leave before the nominal bit end so an early start edge is caught.
                        if (bit_cnt == last_k) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (!frame_bad && smp) begin
                                p_data     <= shreg;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;
  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx_in = 1'b1;
  logic               par_en = 1'b0;
  logic               par_typ = 1'b0;
  logic               stop2 = 1'b0;
  logic [PRESC_W-1:0] prescale = 6'd8;
  logic [DATA_W-1:0]  p_data;
  logic               data_valid, par_err, stp_err, busy;
  logic [2:0]         state_dbg;

  uart_rx_frame_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                exp_lat_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int last_start = 0;
  int dv_cnt = 0, par_cnt = 0, stp_cnt = 0;
  int last_dv_lat = -1, busy_fall_lat = -1, busy_high_cnt = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_cnt++;
        last_dv_lat = cyc - last_start;
        if (exp_q.size() == 0) begin
          check("unexpected_data_valid", 32'd1, 32'd0);
        end else begin
          check("p_data", 32'(p_data), 32'(exp_q.pop_front()));
          check("dv_latency", 32'(last_dv_lat), 32'(exp_lat_q.pop_front()));
        end
      end
      if (par_err) par_cnt++;
      if (stp_err) stp_cnt++;
      if (busy) busy_high_cnt++;
      if (busy_prev && !busy) busy_fall_lat = cyc - last_start;
      busy_prev = busy;
    end else begin
      busy_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx_in = 1'b1;
    end
  endtask

  // Drives one frame bit by bit. spike_k/spike_j invert one cycle;
  // abort_k asserts reset at the start of that bit and returns.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic pe,
                            input logic pt, input logic s2, input int p,
                            input logic flip_par, input logic stop1_low,
                            input int spike_k, input int spike_j,
                            input int abort_k, input logic good,
                            input logic [DATA_W-1:0] exp_data);
    logic bits[16];
    int n;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[n++] = data[i];
    if (pe) bits[n++] = (^data) ^ pt ^ flip_par;
    bits[n++] = ~stop1_low;
    if (s2) bits[n++] = 1'b1;
    par_en = pe;
    par_typ = pt;
    stop2 = s2;
    prescale = PRESC_W'(p);
    if (good) begin
      exp_q.push_back(exp_data);
      exp_lat_q.push_back(2 + (n - 1) * p + p / 2 + MAJ + 1);
    end
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        @(posedge clk);
        #1;
        if (k == abort_k) begin
          rx_in = 1'b1;
          rst_n = 1'b0;
          return;
        end
        if (k == 0 && j == 0) last_start = cyc;
        rx_in = bits[k] ^ ((k == spike_k) && (j == spike_j));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_data"}, 32'(p_data), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_par_err"}, 32'(par_err), 32'd0);
    check({tag, "_stp_err"}, 32'(stp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
  endtask

  int dv0, par0, stp0;

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    idle(5);

    // good frame 0xA5, P=8, even parity, 1 stop
    dv0 = dv_cnt; par0 = par_cnt; stp0 = stp_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, -1, -1, 1'b1, 8'hA5);
    idle(10);
    check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("a5_latency_abs", 32'(last_dv_lat), 32'(87 + MAJ));
    check("a5_no_par_err", 32'(par_cnt - par0), 32'd0);
    check("a5_no_stp_err", 32'(stp_cnt - stp0), 32'd0);

    // same frame with parity flipped, then good 0x3C
    dv0 = dv_cnt; par0 = par_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0, -1, -1, -1, 1'b0, 8'h00);
    idle(10);
    check("parflip_par_err", 32'(par_cnt - par0), 32'd1);
    check("parflip_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("parflip_p_data_held", 32'(p_data), 32'hA5);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, -1, -1, 1'b1, 8'h3C);
    idle(10);
    // odd parity at P=32
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 32, 1'b0, 1'b0, -1, -1, -1, 1'b1, 8'h81);
    idle(10);

    // reset during data bit 4, then clean 0x5A
    dv0 = dv_cnt;
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, -1, -1, 5, 1'b0, 8'h00);
    #1 check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
    idle(5);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, -1, -1, -1, 1'b1, 8'h5A);
    idle(10);
    check("midrst_5a_dv", 32'(dv_cnt - dv0), 32'd1);

    // first stop bit low, two stop bits, no parity, P=16
    dv0 = dv_cnt; stp0 = stp_cnt;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1, -1, -1, -1, 1'b0, 8'h00);
    idle(10);
    check("stop_stp_err_once", 32'(stp_cnt - stp0), 32'd1);
    check("stop_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("stop_busy_fall", 32'(busy_fall_lat), 32'(2 + 10 * 16 + 8 + MAJ + 1));

    // 2-cycle glitch on idle line, P=16
    dv0 = dv_cnt; par0 = par_cnt; stp0 = stp_cnt;
    prescale = 6'd16;
    @(posedge clk);
    #1 busy_high_cnt = 0;
    rx_in = 1'b0;
    @(posedge clk);
    #1 rx_in = 1'b0;
    idle(40);
    check("glitch_busy_cycles", 32'(busy_high_cnt), 32'(8 + MAJ));
    check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_no_err", 32'((par_cnt - par0) + (stp_cnt - stp0)), 32'd0);

    // one-cycle spike at P/2 of data bit 3 in 0x00, P=8
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 4, 4, -1, 1'b1,
               (MAJ == 1) ? 8'h00 : 8'h08);
    idle(10);

    // random good frames
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] d;
      int p;
      d = DATA_W'($urandom_range(0, 255));
      p = 8 << $urandom_range(0, 2);
      send_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), p, 1'b0, 1'b0, -1, -1, -1, 1'b1, d);
      idle($urandom_range(2, 12));
    end

    // drain, bounded
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
